// File: rtl/hilo_pkg.sv
// rtl/hilo_pkg.sv - shared op encodings, FSM states and default latencies for the HI/LO stage
package hilo_pkg;

  localparam int DEF_W       = 32;
  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 32;

  typedef enum logic [1:0] {
    OP_MUL  = 2'b00,
    OP_DIV  = 2'b01,
    OP_MTHI = 2'b10,
    OP_MTLO = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/hilo_lat_cnt.sv
// rtl/hilo_lat_cnt.sv - loadable down-counter that flags the last busy cycle
module hilo_lat_cnt #(
  parameter int CW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          last
);

  // load takes priority over decrement; reset clears the count
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  // the cycle holding count 1 is the final busy cycle before commit
  always_comb begin
    last = (cnt == CW'(1));
  end

endmodule

// File: rtl/hilo_unit.sv
// rtl/hilo_unit.sv - HI/LO register stage with modelled mult/div latency (optional HILO_FWD_EN)
module hilo_unit
  import hilo_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  output logic         ready,
  input  logic [W-1:0] alu_lo,
  input  logic [W-1:0] alu_hi,
  input  logic         alu_o,
  input  logic         alu_z,
  input  logic [W-1:0] wr_data,
  input  logic         rd_sel,
  input  logic         rd_req,
  output logic [W-1:0] rd_data,
  output logic         rd_stall,
  output logic         busy,
  output logic         done,
  output logic         div0
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW      = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] MUL_LD = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] DIV_LD = CW'(DIV_LAT - 1);

  op_e           op_q;
  state_e        state_q, state_d;
  logic [W-1:0]  hi_q, lo_q;
  logic [W-1:0]  pend_hi_q, pend_lo_q;
  logic          pend_div0_q;
  logic          accept_md, accept_mt;
  logic          cnt_load, cnt_dec, cnt_last;
  logic [CW-1:0] cnt_ld_val, cnt;

  assign op_q      = op_e'(op);
  assign accept_md = (state_q == S_IDLE) && start && !op_q[1];
  assign accept_mt = (state_q == S_IDLE) && start &&  op_q[1];

  hilo_lat_cnt #(.CW(CW)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_ld_val),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .last     (cnt_last)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next state and counter control; a latency of one skips BUSY entirely
  always_comb begin
    state_d    = state_q;
    cnt_load   = 1'b0;
    cnt_ld_val = '0;
    cnt_dec    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_md) begin
          cnt_ld_val = (op_q == OP_DIV) ? DIV_LD : MUL_LD;
          if (cnt_ld_val == '0) begin
            state_d = S_DONE;
          end else begin
            cnt_load = 1'b1;
            state_d  = S_BUSY;
          end
        end
      end
      S_BUSY: begin
        cnt_dec = 1'b1;
        if (cnt_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // pending capture on accept, direct moves, and commit in DONE unless divide-by-zero
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q        <= '0;
      lo_q        <= '0;
      pend_hi_q   <= '0;
      pend_lo_q   <= '0;
      pend_div0_q <= 1'b0;
    end else begin
      if (accept_md) begin
        pend_hi_q   <= alu_hi;
        pend_lo_q   <= alu_lo;
        pend_div0_q <= (op_q == OP_DIV) && alu_o && alu_z;
      end
      if (accept_mt && (op_q == OP_MTHI)) begin
        hi_q <= wr_data;
      end
      if (accept_mt && (op_q == OP_MTLO)) begin
        lo_q <= wr_data;
      end
      if ((state_q == S_DONE) && !pend_div0_q) begin
        hi_q <= pend_hi_q;
        lo_q <= pend_lo_q;
      end
    end
  end

  // handshake, status pulses and the read port
  always_comb begin
    ready = (state_q == S_IDLE);
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);
    div0  = (state_q == S_DONE) && pend_div0_q;
`ifdef HILO_FWD_EN
    rd_stall = rd_req && (state_q == S_BUSY);
    if ((state_q == S_DONE) && !pend_div0_q) begin
      rd_data = rd_sel ? pend_hi_q : pend_lo_q;
    end else begin
      rd_data = rd_sel ? hi_q : lo_q;
    end
`else
    rd_stall = rd_req && busy;
    rd_data  = rd_sel ? hi_q : lo_q;
`endif
  end

endmodule

// File: tb/tb_hilo_unit.sv
// tb/tb_hilo_unit.sv - randomized self-checking bench for hilo_unit against a latency model
module tb_hilo_unit;

  localparam int W       = 32;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;

  logic         clk = 1'b0;
  logic         rst, start, alu_o, alu_z, rd_sel, rd_req;
  logic [1:0]   op;
  logic [W-1:0] alu_lo, alu_hi, wr_data, rd_data;
  logic         ready, rd_stall, busy, done, div0;

  int checks   = 0;
  int failures = 0;

  // behavioural model: architectural HI/LO plus one outstanding result with cycles left
  logic [W-1:0] m_hi, m_lo, m_phi, m_plo;
  logic         m_pdiv0, m_act;
  int           m_left;

  always #5 clk = ~clk;

  hilo_unit #(.W(W), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .ready(ready),
    .alu_lo(alu_lo), .alu_hi(alu_hi), .alu_o(alu_o), .alu_z(alu_z),
    .wr_data(wr_data), .rd_sel(rd_sel), .rd_req(rd_req), .rd_data(rd_data),
    .rd_stall(rd_stall), .busy(busy), .done(done), .div0(div0)
  );

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic [1:0] o_p, input logic [31:0] ahi, alo,
                      input logic ao, az, input logic [31:0] wd, input logic rs, rr, r);
    logic        e_done, e_div0, e_stall;
    logic [31:0] e_data;
    @(negedge clk);
    start = st; op = o_p; alu_hi = ahi; alu_lo = alo; alu_o = ao; alu_z = az;
    wr_data = wd; rd_sel = rs; rd_req = rr; rst = r;
    #1;
    e_done = m_act && (m_left == 0);
    e_div0 = e_done && m_pdiv0;
    e_data = rs ? m_hi : m_lo;
`ifdef HILO_FWD_EN
    e_stall = rr && m_act && (m_left != 0);
    if (e_done && !m_pdiv0) e_data = rs ? m_phi : m_plo;
`else
    e_stall = rr && m_act;
`endif
    check_val("ready", 32'(ready), 32'(!m_act));
    check_val("busy", 32'(busy), 32'(m_act));
    check_val("done", 32'(done), 32'(e_done));
    check_val("div0", 32'(div0), 32'(e_div0));
    check_val("rd_stall", 32'(rd_stall), 32'(e_stall));
    check_val("rd_data", rd_data, e_data);
    if (r) begin
      m_hi = '0; m_lo = '0; m_act = 1'b0; m_left = 0;
    end else if (m_act) begin
      if (m_left == 0) begin
        if (!m_pdiv0) begin m_hi = m_phi; m_lo = m_plo; end
        m_act = 1'b0;
      end else begin
        m_left--;
      end
    end else if (st) begin
      if (o_p == 2'b00 || o_p == 2'b01) begin
        m_phi = ahi; m_plo = alo;
        m_pdiv0 = (o_p == 2'b01) && ao && az;
        m_act = 1'b1;
        m_left = ((o_p == 2'b01) ? DIV_LAT : MUL_LAT) - 1;
      end else if (o_p == 2'b10) begin
        m_hi = wd;
      end else begin
        m_lo = wd;
      end
    end
  endtask

  task automatic idle(input logic rr, rs);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, rs, rr, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 2'b00; alu_hi = '0; alu_lo = '0; alu_o = 1'b0;
    alu_z = 1'b0; wr_data = '0; rd_sel = 1'b0; rd_req = 1'b0;
    m_hi = '0; m_lo = '0; m_phi = '0; m_plo = '0; m_pdiv0 = 1'b0; m_act = 1'b0; m_left = 0;
    repeat (2) @(posedge clk);
    idle(1'b1, 1'b1);
    check_val("reset_hi", rd_data, 32'h0);

    // 1: MUL, done at t+4, readable at t+5
    step(1'b1, 2'b00, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (3) idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check_val("t1_done", 32'(done), 32'h1);
    idle(1'b1, 1'b1);
    check_val("t1_hi", rd_data, 32'h0000_0001);
    idle(1'b1, 1'b0);
    check_val("t1_lo", rd_data, 32'h8000_0000);

    // 2: divide by zero keeps HI/LO
    step(1'b1, 2'b01, 32'hAAAA_AAAA, 32'hBBBB_BBBB, 1'b1, 1'b1, '0, 1'b0, 1'b0, 1'b0);
    repeat (31) idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check_val("t2_div0", 32'(div0), 32'h1);
    idle(1'b0, 1'b1);
    check_val("t2_hi", rd_data, 32'h0000_0001);

    // 3: MTHI then MFHI
    step(1'b1, 2'b10, '0, '0, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b1);
    check_val("t3_hi", rd_data, 32'hDEAD_BEEF);
    check_val("t3_stall", 32'(rd_stall), 32'h0);

    // 4: MFLO during BUSY and at DONE
    step(1'b1, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
    check_val("t4_stall_busy", 32'(rd_stall), 32'h1);
    idle(1'b1, 1'b0);
    idle(1'b1, 1'b0);
`ifdef HILO_FWD_EN
    check_val("t4_fwd_stall", 32'(rd_stall), 32'h0);
    check_val("t4_fwd_data", rd_data, 32'h2222_2222);
`else
    check_val("t4_stall_done", 32'(rd_stall), 32'h1);
    check_val("t4_old_lo", rd_data, 32'h8000_0000);
`endif
    idle(1'b0, 1'b0);

    // 5: start held while busy, second op accepted at t+5, done at t+9
    step(1'b1, 2'b00, 32'h1, 32'h2, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (4) step(1'b1, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 2'b00, 32'h3, 32'h4, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check_val("t5_ready", 32'(ready), 32'h1);
    repeat (3) idle(1'b0, 1'b0);
    idle(1'b0, 1'b0);
    check_val("t5_done", 32'(done), 32'h1);
    idle(1'b0, 1'b1);
    check_val("t5_hi", rd_data, 32'h3);

    // 6: reset aborts a divide
    step(1'b1, 2'b01, 32'h5, 32'h6, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0);
    step(1'b0, 2'b00, '0, '0, 1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b1, 1'b1);
    check_val("t6_busy", 32'(busy), 32'h0);
    check_val("t6_hi", rd_data, 32'h0);
    repeat (40) idle(1'b1, 1'b0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)), $urandom, $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1), $urandom,
           ($urandom_range(0, 1) == 1), ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 299) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
